// File: rtl/fbrc_seq_ctrl_pkg.sv
// Shared types and constants for the counter run sequencer.
package fbrc_pkg;

    localparam int unsigned NREQ          = 2;
    localparam int unsigned DEFAULT_WIDTH = 4;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        DONE = 2'b10
    } state_e;

endpackage

// File: rtl/fbrc_seq_ctrl_if.sv
// Requester-side bus of the run sequencer: requests, lengths, abort and run status.
interface fbrc_seq_ctrl_if
    import fbrc_pkg::*;
#(
    parameter int unsigned WIDTH = DEFAULT_WIDTH
) ();

    logic [NREQ-1:0]  req;
    logic [WIDTH-1:0] len0;
    logic [WIDTH-1:0] len1;
    logic             abort;
    logic [NREQ-1:0]  gnt;
    logic [NREQ-1:0]  done;
    logic             busy;
    logic [WIDTH-1:0] count;

    modport master (
        output req, len0, len1, abort,
        input  gnt, done, busy, count
    );

    modport slave (
        input  req, len0, len1, abort,
        output gnt, done, busy, count
    );

endinterface

// File: rtl/fbrc_seq_ctrl_rr_arb.sv
// Two-way round-robin pick; rr names the requester served last, so the other wins a tie.
module fbrc_rr_arb
    import fbrc_pkg::*;
(
    input  logic [NREQ-1:0] req_i,
    input  logic            rr_i,
    output logic [NREQ-1:0] gnt_o,
    output logic            valid_o
);

    always_comb begin
        gnt_o   = '0;
        valid_o = |req_i;
        case (req_i)
            2'b01:   gnt_o = 2'b01;
            2'b10:   gnt_o = 2'b10;
            2'b11:   gnt_o = rr_i ? 2'b01 : 2'b10;
            default: gnt_o = '0;
        endcase
    end

endmodule

// File: rtl/fbrc_seq_ctrl.sv
// Run sequencer: grants the counter to one requester, counts 0..len, pulses done to the owner.
module fbrc_seq_ctrl
    import fbrc_pkg::*;
#(
    parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
    input  logic          clk,
    input  logic          reset,
    fbrc_seq_ctrl_if.slave bus
);

    state_e           state_q, state_d;
    logic [NREQ-1:0]  gnt_q, gnt_d;
    logic [NREQ-1:0]  done_q, done_d;
    logic [WIDTH-1:0] count_q, count_d;
    logic [WIDTH-1:0] len_q, len_d;
    logic             rr_q, rr_d;

    logic [NREQ-1:0]  arb_gnt;
    logic             arb_valid;
    logic             at_end;

    fbrc_rr_arb u_arb (
        .req_i   (bus.req),
        .rr_i    (rr_q),
        .gnt_o   (arb_gnt),
        .valid_o (arb_valid)
    );

    assign at_end = (count_q == len_q);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            gnt_q   <= '0;
            done_q  <= '0;
            count_q <= '0;
            len_q   <= '0;
            rr_q    <= 1'b1;
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            done_q  <= done_d;
            count_q <= count_d;
            len_q   <= len_d;
            rr_q    <= rr_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (arb_valid) state_d = RUN;
            RUN: begin
                if (bus.abort)   state_d = IDLE;
                else if (at_end) state_d = DONE;
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Owner is gnt_q while running and done_q during the completion cycle.
    always_comb begin
        gnt_d   = gnt_q;
        done_d  = '0;
        count_d = count_q;
        len_d   = len_q;
        rr_d    = rr_q;
        case (state_q)
            IDLE: begin
                if (arb_valid) begin
                    gnt_d   = arb_gnt;
                    count_d = '0;
                    len_d   = arb_gnt[1] ? bus.len1 : bus.len0;
                end
            end
            RUN: begin
                if (bus.abort) begin
                    gnt_d   = '0;
                    count_d = '0;
                    rr_d    = gnt_q[1];
                end else if (at_end) begin
                    gnt_d  = '0;
                    done_d = gnt_q;
                end else begin
                    count_d = count_q + WIDTH'(1);
                end
            end
            DONE: begin
                count_d = '0;
                rr_d    = done_q[1];
            end
            default: begin
                gnt_d   = '0;
                count_d = '0;
            end
        endcase
    end

    assign bus.gnt   = gnt_q;
    assign bus.done  = done_q;
    assign bus.count = count_q;
    assign bus.busy  = (state_q != IDLE);

endmodule

// File: tb/tb_fbrc_seq_ctrl.sv
// Directed bench for fbrc_seq_ctrl: single runs, round-robin ties, len=0, abort, async reset, mid-run input changes.
module tb_fbrc_seq_ctrl;

    logic clk;
    logic reset;
    int   n_checks;
    int   n_pass;

    fbrc_seq_ctrl_if #(.WIDTH(4)) bus ();

    fbrc_seq_ctrl #(.WIDTH(4)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input int obs, input int exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Called right after the grant edge; walks count 0..l, the done cycle and the trailing IDLE cycle.
    task automatic expect_run(input string tag, input int g, input int l);
        for (int i = 0; i <= l; i++) begin
            chk({tag, ".gnt"},   int'(bus.gnt),   g);
            chk({tag, ".count"}, int'(bus.count), i);
            chk({tag, ".done"},  int'(bus.done),  0);
            chk({tag, ".busy"},  int'(bus.busy),  1);
            step();
        end
        chk({tag, ".dgnt"},   int'(bus.gnt),   0);
        chk({tag, ".dpulse"}, int'(bus.done),  g);
        chk({tag, ".dcount"}, int'(bus.count), l);
        chk({tag, ".dbusy"},  int'(bus.busy),  1);
        step();
        chk({tag, ".idone"},  int'(bus.done),  0);
        chk({tag, ".igut"},   int'(bus.gnt),   0);
        chk({tag, ".icount"}, int'(bus.count), 0);
        chk({tag, ".ibusy"},  int'(bus.busy),  0);
    endtask

    task automatic do_reset();
        reset = 1'b0;
        step();
        step();
        reset = 1'b1;
    endtask

    initial begin
        n_checks  = 0;
        n_pass    = 0;
        reset     = 1'b0;
        bus.req   = 2'b00;
        bus.len0  = 4'd0;
        bus.len1  = 4'd0;
        bus.abort = 1'b0;
        step();

        // reset state
        chk("rst.gnt",   int'(bus.gnt),   0);
        chk("rst.done",  int'(bus.done),  0);
        chk("rst.count", int'(bus.count), 0);
        chk("rst.busy",  int'(bus.busy),  0);
        reset = 1'b1;
        step();
        chk("idle.busy", int'(bus.busy), 0);

        // single run, len0=3
        bus.req  = 2'b01;
        bus.len0 = 4'd3;
        step();
        bus.req = 2'b00;
        expect_run("r0len3", 1, 3);

        // held tie from reset: 0,1,0,1
        do_reset();
        bus.req  = 2'b11;
        bus.len0 = 4'd1;
        bus.len1 = 4'd2;
        step();
        expect_run("tie1", 1, 1);
        step();
        expect_run("tie2", 2, 2);
        step();
        expect_run("tie3", 1, 1);
        step();
        bus.req = 2'b00;
        expect_run("tie4", 2, 2);

        // len=0 on requester 1
        bus.req  = 2'b10;
        bus.len1 = 4'd0;
        step();
        bus.req = 2'b00;
        expect_run("len0", 2, 0);

        // abort at count=5 with requester 1 pending
        bus.req  = 2'b01;
        bus.len0 = 4'd15;
        bus.len1 = 4'd1;
        step();
        bus.req = 2'b10;
        chk("ab.gnt0", int'(bus.gnt), 1);
        for (int i = 1; i <= 5; i++) begin
            step();
            chk("ab.count", int'(bus.count), i);
        end
        bus.abort = 1'b1;
        step();
        bus.abort = 1'b0;
        chk("ab.gnt",   int'(bus.gnt),   0);
        chk("ab.count0", int'(bus.count), 0);
        chk("ab.done",  int'(bus.done),  0);
        chk("ab.busy",  int'(bus.busy),  0);
        step();
        bus.req = 2'b00;
        expect_run("ab.next", 2, 1);

        // abort coinciding with count==len
        bus.req  = 2'b01;
        bus.len0 = 4'd1;
        step();
        bus.req = 2'b00;
        step();
        chk("abend.count", int'(bus.count), 1);
        bus.abort = 1'b1;
        step();
        bus.abort = 1'b0;
        chk("abend.gnt",  int'(bus.gnt),  0);
        chk("abend.done", int'(bus.done), 0);
        chk("abend.busy", int'(bus.busy), 0);
        step();
        chk("abend.done2", int'(bus.done), 0);

        // asynchronous reset mid-run, then a tie goes to requester 0
        bus.req  = 2'b01;
        bus.len0 = 4'd9;
        step();
        bus.req = 2'b00;
        for (int i = 0; i < 4; i++) step();
        chk("ar.count4", int'(bus.count), 4);
        #2;
        reset = 1'b0;
        #1;
        chk("ar.gnt",   int'(bus.gnt),   0);
        chk("ar.count", int'(bus.count), 0);
        chk("ar.done",  int'(bus.done),  0);
        chk("ar.busy",  int'(bus.busy),  0);
        bus.req  = 2'b11;
        bus.len0 = 4'd2;
        step();
        chk("ar.hold", int'(bus.gnt), 0);
        reset = 1'b1;
        step();
        bus.req = 2'b00;
        expect_run("ar.first", 1, 2);

        // len and req changes during RUN are ignored
        bus.req  = 2'b01;
        bus.len0 = 4'd2;
        step();
        bus.len0 = 4'd7;
        bus.req  = 2'b00;
        expect_run("ign", 1, 2);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/fbrc_seq_ctrl.md
# fbrc_seq_ctrl

Run sequencer and arbiter for the 4-bit counter resource. Two requesters each ask for a counting run of a given length. The block grants the counter to one of them at a time in round-robin order, drives the count from 0 up to the requested terminal value, and returns a one-cycle completion pulse to the owner. It sits between the requesting control logic and the counter output bus, and is the only block that starts, stops or clears the counter.

## Interface
Parameters:
- WIDTH, 4, counter and length width in bits.

Ports:
- clk  in  1  system clock, rising-edge.
- reset  in  1  asynchronous, active-low reset. Low clears all state immediately, regardless of clk.
- req  in  2  per-requester run request; level, held by the requester until its gnt bit rises.
- len0  in  WIDTH  terminal count for requester 0; sampled only on its grant edge.
- len1  in  WIDTH  terminal count for requester 1; sampled only on its grant edge.
- abort  in  1  terminate the current run; honoured only in RUN.
- gnt  out  2  one-hot ownership; high for the whole RUN phase.
- done  out  2  one-hot, one-cycle completion pulse to the owner.
- busy  out  1  high whenever state is not IDLE.
- count  out  WIDTH  current counter value.

## Operation
- States: IDLE, RUN, DONE.
- IDLE:
  - If req is 0: hold state.
  - If req is non-zero: pick a winner. A single requester wins outright. If both request, the winner is the requester not served last (pointer rr).
  - On the edge: state becomes RUN, gnt becomes onehot(winner), count becomes 0, len_q takes the winner's len.
- RUN, priority order on each edge:
  - abort=1: state becomes IDLE, gnt becomes 0, count becomes 0, rr becomes owner. No done pulse.
  - else count==len_q: state becomes DONE, gnt becomes 0, done becomes onehot(owner), count is held.
  - else count increments by 1. No wrap-around is possible because count never exceeds len_q ≤ 2^WIDTH−1.
- DONE:
  - On the edge: state becomes IDLE, done becomes 0, count becomes 0, rr becomes owner.
  - Requests are not evaluated in DONE.
- During RUN, changes on req and len are ignored. A requester that drops req mid-run still receives done.
- len=0 is legal: RUN lasts one cycle with count=0, then DONE.
- Outputs (gnt, done, count) are registered. busy is decoded from the state register.
- Reset values: state IDLE, gnt 0, done 0, count 0, busy 0, len_q 0, rr 1 (so requester 0 wins the first tie).
- Reset asserted mid-run drops gnt, done and count to 0 immediately. After release the block arbitrates afresh with rr=1. No done pulse is issued for the interrupted run.

## Timing
- Grant latency: req sampled high in IDLE at edge E0 gives gnt high from E0.
- gnt stays high for exactly len+1 cycles, with count showing 0,1,…,len.
- done is high for exactly 1 cycle, the cycle after count==len. gnt is low during that cycle.
- Minimum run cost is len+3 cycles: RUN len+1, DONE 1, IDLE 1. There is always at least one IDLE cycle between consecutive grants.
- An abort sampled at edge Ea clears gnt and count at Ea. The next grant is possible at Ea+1.
- Simultaneous abort and count==len: abort wins, and no done is issued.

## Structure
- Package fbrc_pkg:
  - state encoding constants IDLE=2'b00, RUN=2'b01, DONE=2'b10;
  - NREQ=2;
  - default WIDTH=4.
- Sub-module fbrc_rr_arb: combinational two-way round-robin pick. Inputs are req[1:0] and rr; outputs are a one-hot grant and a valid flag. Instantiated once.
- The counter, len_q, FSM and rr register live in fbrc_seq_ctrl.

## Test plan
- Reset, then release. Drive req=01, len0=3. Required: gnt=01 for 4 cycles with count 0,1,2,3; then done=01 for 1 cycle; then count=0 and busy=0.
- Hold req=11 continuously with len0=1 and len1=2, starting from reset. Required grant order: 0, 1, 0, 1. Each done arrives on the matching bit. Exactly one IDLE cycle separates the runs.
- req=10 with len1=0. Required: gnt=10 for 1 cycle with count=0, then done=10.
- req=01 with len0=15, then abort at count=5. Required: gnt and count go to 0 on that edge and no done is issued. A pending req=10 is granted on the next edge.
- req=01 with len0=9. Pull reset low at count=4, with no clock edge. Required: gnt, count and done are 0 at once. After release with req=11, requester 0 is granted first.
- req=01 with len0=2. Change len0 to 7 and drop req during RUN. Required: the run still ends at count=2 and done=01 is issued.
